// File: rtl/trace_dispatch_if.sv
// Trace-record intake and cache command bundle for trace_dispatch.
// master = trace reader + cache side, slave = the dispatcher.
interface trace_dispatch_if #(
  parameter int I_SIZE = 32
) ();
  // Intake: a record transfers on a rising edge where in_valid && in_ready.
  // in_command/in_address must be stable while in_valid is high.
  // Cache: command/instruction are held while cmd_valid is high; the command
  // completes on the edge where cmd_valid && cmd_ack, with hit/miss valid then.
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_command;
  logic [I_SIZE-1:0] in_address;
  logic              cmd_valid;
  logic              cmd_ack;
  logic [3:0]        command;
  logic [I_SIZE-1:0] instruction;
  logic              hit;
  logic              miss;

  modport master (
    output in_valid, in_command, in_address, cmd_ack, hit, miss,
    input  in_ready, cmd_valid, command, instruction
  );

  modport slave (
    input  in_valid, in_command, in_address, cmd_ack, hit, miss,
    output in_ready, cmd_valid, command, instruction
  );
endinterface

// File: rtl/trace_dispatch.sv
// Buffers trace records, issues them to the cache, handles clear/print locally
// and keeps hit/miss statistics. Define ACK_TIMEOUT_EN to add an ack watchdog.
module trace_dispatch #(
  parameter int I_SIZE     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  trace_dispatch_if.slave   bus,
  output logic              clear_req,
  output logic              print_req,
  output logic              busy,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 4 + I_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CLEAR, S_PRINT} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;
  logic [RW-1:0]     head;
  logic [3:0]        head_cmd;
  logic [3:0]        cmd_q, cmd_d;
  logic [I_SIZE-1:0] ins_q, ins_d;
  logic              rd_inc, wr_inc, hit_inc, miss_inc, err_inc, cnt_clr;
  logic              ack_seen;
  logic [CNT_W-1:0]  read_q, write_q, hit_q, miss_q, err_q;
  logic [CNT_W-1:0]  read_d, write_d, hit_d, miss_d, err_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = bus.in_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_cmd = head[RW-1:I_SIZE];
  assign ack_seen = (state_q == S_ISSUE) && bus.cmd_ack;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_command, bus.in_address};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (state_q == S_ISSUE) && !bus.cmd_ack && (tmo_q == TW'(TIMEOUT - 1));
  assign tmo_d   = (state_q == S_ISSUE && !bus.cmd_ack && !tmo_hit) ? tmo_q + TW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    cmd_d    = cmd_q;
    ins_d    = ins_q;
    rd_inc   = 1'b0;
    wr_inc   = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    err_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cmd_d = head_cmd;
          ins_d = head[I_SIZE-1:0];
          if (head_cmd <= 4'd6)      state_d = S_ISSUE;
          else if (head_cmd == 4'd8) state_d = S_CLEAR;
          else if (head_cmd == 4'd9) state_d = S_PRINT;
          else                       err_inc = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ack_seen) begin
          state_d = S_IDLE;
          rd_inc  = (cmd_q == 4'd0) || (cmd_q == 4'd2);
          wr_inc  = (cmd_q == 4'd1);
          // Snoop codes 3-6 complete without touching the statistics.
          if (cmd_q <= 4'd2) begin
            if (bus.miss)     miss_inc = 1'b1;
            else if (bus.hit) hit_inc  = 1'b1;
            err_inc = (bus.hit && bus.miss) || (!bus.hit && !bus.miss);
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_inc = 1'b1;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      S_PRINT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    read_d  = cnt_clr ? '0 : sat_inc(read_q,  rd_inc);
    write_d = cnt_clr ? '0 : sat_inc(write_q, wr_inc);
    hit_d   = cnt_clr ? '0 : sat_inc(hit_q,   hit_inc);
    miss_d  = cnt_clr ? '0 : sat_inc(miss_q,  miss_inc);
    err_d   = sat_inc(err_q, err_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ins_q   <= '0;
      read_q  <= '0;
      write_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ins_q   <= ins_d;
      read_q  <= read_d;
      write_q <= write_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.cmd_valid   = (state_q == S_ISSUE);
  assign bus.command     = cmd_q;
  assign bus.instruction = ins_q;
  assign clear_req       = (state_q == S_CLEAR);
  assign print_req       = (state_q == S_PRINT);
  assign busy            = !empty || (state_q != S_IDLE);
  assign read_count      = read_q;
  assign write_count     = write_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;
  assign err_count       = err_q;
  assign dbg_state_o     = state_q;

endmodule
